// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // Register x0 is hardwired to zero, so it never carries a dependency.
    function automatic logic dep_hit(input logic [4:0] src, input logic [4:0] rd, input logic wr);
        return wr && (rd != 5'd0) && (rd == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] rd_mem, input logic wr_mem,
                                           input logic [4:0] rd_wb,  input logic wr_wb);
        if (dep_hit(src, rd_mem, wr_mem)) return FWD_EXMEM;
        if (dep_hit(src, rd_wb, wr_wb))   return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use / RAW stall request and EX operand forwarding selects.
// PIPE_CTRL_FWD_EN enables forwarding; without it every RAW dependency stalls.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic       use_rs1_ID,
    input  logic       use_rs2_ID,
    input  logic [4:0] rs1_EX,
    input  logic [4:0] rs2_EX,
    input  logic [4:0] rd_EX,
    input  logic       regwrite_EX,
    input  logic       memread_EX,
    input  logic [4:0] rd_MEM,
    input  logic       regwrite_MEM,
    input  logic [4:0] rd_WB,
    input  logic       regwrite_WB,
    output logic       stall_req,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    logic id_dep_ex;

    always_comb begin
        id_dep_ex = (use_rs1_ID && dep_hit(rs1_ID, rd_EX, regwrite_EX)) ||
                    (use_rs2_ID && dep_hit(rs2_ID, rd_EX, regwrite_EX));
`ifdef PIPE_CTRL_FWD_EN
        stall_req = memread_EX && id_dep_ex;
        fwd_a     = fwd_sel(rs1_EX, rd_MEM, regwrite_MEM, rd_WB, regwrite_WB);
        fwd_b     = fwd_sel(rs2_EX, rd_MEM, regwrite_MEM, rd_WB, regwrite_WB);
`else
        // WB is not checked: the register file writes through to ID reads.
        stall_req = id_dep_ex ||
                    (use_rs1_ID && dep_hit(rs1_ID, rd_MEM, regwrite_MEM)) ||
                    (use_rs2_ID && dep_hit(rs2_ID, rd_MEM, regwrite_MEM));
        fwd_a     = FWD_RF;
        fwd_b     = FWD_RF;
`endif
    end

`ifndef PIPE_CTRL_FWD_EN
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{rs1_EX, rs2_EX, rd_WB, regwrite_WB, memread_EX};
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/stall controller: data-memory wait FSM, stage enables/flushes, stall counter.
// Build with PIPE_CTRL_FWD_EN defined to enable operand forwarding.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             rs1_ID,
    input  logic [4:0]             rs2_ID,
    input  logic                   use_rs1_ID,
    input  logic                   use_rs2_ID,
    input  logic [4:0]             rs1_EX,
    input  logic [4:0]             rs2_EX,
    input  logic [4:0]             rd_EX,
    input  logic                   regwrite_EX,
    input  logic                   memread_EX,
    input  logic [4:0]             rd_MEM,
    input  logic                   regwrite_MEM,
    input  logic                   memread_MEM,
    input  logic                   memwrite_MEM,
    input  logic [4:0]             rd_WB,
    input  logic                   regwrite_WB,
    input  logic                   branch_taken_EX,
    input  logic                   dmem_ready,
    output logic                   dmem_req,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   exmem_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   memwb_flush,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   mem_err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    mem_state_t state, state_nxt;
    logic [7:0] wait_cnt;
    logic       mem_op;
    logic       timeout;
    logic       mem_stall;
    logic       hz_stall;
    logic [1:0] hd_fwd_a, hd_fwd_b;

    hazard_detect u_hazard_detect (
        .rs1_ID       (rs1_ID),
        .rs2_ID       (rs2_ID),
        .use_rs1_ID   (use_rs1_ID),
        .use_rs2_ID   (use_rs2_ID),
        .rs1_EX       (rs1_EX),
        .rs2_EX       (rs2_EX),
        .rd_EX        (rd_EX),
        .regwrite_EX  (regwrite_EX),
        .memread_EX   (memread_EX),
        .rd_MEM       (rd_MEM),
        .regwrite_MEM (regwrite_MEM),
        .rd_WB        (rd_WB),
        .regwrite_WB  (regwrite_WB),
        .stall_req    (hz_stall),
        .fwd_a        (hd_fwd_a),
        .fwd_b        (hd_fwd_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            stall_cycles <= '0;
            mem_err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == WAIT) ? wait_cnt + 8'd1 : '0;
            if (!pc_en && (stall_cycles != '1))
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
            if (timeout)
                mem_err <= 1'b1;
        end
    end

    // The first request cycle already stalls when ready is absent, so N late cycles cost N stalls.
    always_comb begin
        mem_op    = memread_MEM | memwrite_MEM;
        timeout   = (state == WAIT) && (wait_cnt == TIMEOUT_CNT) && !dmem_ready;
        mem_stall = !dmem_ready && !timeout && ((state == WAIT) || mem_op);
        state_nxt = state;
        case (state)
            IDLE:    if (mem_op && !dmem_ready) state_nxt = WAIT;
            WAIT:    if (dmem_ready || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dmem_req    = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        fwd_a       = FWD_RF;
        fwd_b       = FWD_RF;
        if (!rst) begin
            dmem_req    = (state == WAIT) || mem_op;
            fwd_a       = hd_fwd_a;
            fwd_b       = hd_fwd_b;
            memwb_flush = timeout;
            if (mem_stall) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_en    = 1'b0;
                memwb_flush = 1'b1;
            end else if (branch_taken_EX) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (hz_stall) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_pipe_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    // {dmem_req, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush}
    localparam logic [7:0] RUN     = 8'b0_1111_000;
    localparam logic [7:0] RUN_REQ = 8'b1_1111_000;
    localparam logic [7:0] LU      = 8'b0_0011_010;
    localparam logic [7:0] LU_REQ  = 8'b1_0011_010;
    localparam logic [7:0] MSTALL  = 8'b1_0000_001;
    localparam logic [7:0] BR      = 8'b0_1111_110;
    localparam logic [7:0] BR_REQ  = 8'b1_1111_110;
    localparam logic [7:0] TOUT    = 8'b1_1111_001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
    logic use_rs1_ID, use_rs2_ID, regwrite_EX, memread_EX, regwrite_MEM, memread_MEM;
    logic memwrite_MEM, regwrite_WB, branch_taken_EX, dmem_ready;
    logic dmem_req, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] stall_cycles;
    logic mem_err;
    logic [7:0] ctl;
    logic [3:0] fwd;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state: access in progress, cycles since its first request, counters.
    bit m_active = 0;
    int m_n = 0;
    bit m_err = 0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    assign ctl = {dmem_req, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush};
    assign fwd = {fwd_a, fwd_b};

    pipe_ctrl #(.MEM_TIMEOUT(TO), .STALL_CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
        .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX), .regwrite_EX(regwrite_EX),
        .memread_EX(memread_EX), .rd_MEM(rd_MEM), .regwrite_MEM(regwrite_MEM),
        .memread_MEM(memread_MEM), .memwrite_MEM(memwrite_MEM), .rd_WB(rd_WB),
        .regwrite_WB(regwrite_WB), .branch_taken_EX(branch_taken_EX), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_flush(memwb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cycles(stall_cycles), .mem_err(mem_err)
    );

    function automatic bit dep(input logic [4:0] src, input logic u, input logic [4:0] rd, input logic w);
        return u && w && (rd != 0) && (rd == src);
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] src);
        logic [1:0] f;
        if (dep(src, 1'b1, rd_MEM, regwrite_MEM)) f = 2'b10;
        else if (dep(src, 1'b1, rd_WB, regwrite_WB)) f = 2'b01;
        else f = 2'b00;
`ifndef PIPE_CTRL_FWD_EN
        f = 2'b00;
`endif
        return f;
    endfunction

    function automatic logic [11:0] model_out();
        logic acc, tmo, hold, hz;
        logic [7:0] c;
        if (rst) return {RUN, 4'b0000};
        acc  = m_active || memread_MEM || memwrite_MEM;
        tmo  = m_active && (m_n == TO + 1) && !dmem_ready;
        hold = acc && !dmem_ready && !tmo;
`ifdef PIPE_CTRL_FWD_EN
        hz = memread_EX && (dep(rs1_ID, use_rs1_ID, rd_EX, regwrite_EX) ||
                            dep(rs2_ID, use_rs2_ID, rd_EX, regwrite_EX));
`else
        hz = dep(rs1_ID, use_rs1_ID, rd_EX, regwrite_EX) || dep(rs2_ID, use_rs2_ID, rd_EX, regwrite_EX) ||
             dep(rs1_ID, use_rs1_ID, rd_MEM, regwrite_MEM) || dep(rs2_ID, use_rs2_ID, rd_MEM, regwrite_MEM);
`endif
        if (hold)                 c = MSTALL;
        else if (branch_taken_EX) c = {acc, 4'b1111, 2'b11, tmo};
        else if (hz)              c = {acc, 4'b0011, 2'b01, tmo};
        else                      c = {acc, 4'b1111, 2'b00, tmo};
        return {c, fsel(rs1_EX), fsel(rs2_EX)};
    endfunction

    function automatic void model_seq();
        logic [11:0] e;
        e = model_out();
        if (rst) begin
            m_active = 0; m_n = 0; m_err = 0; m_cnt = 0;
            return;
        end
        if (m_active || memread_MEM || memwrite_MEM) begin
            if (dmem_ready || (m_active && m_n == TO + 1)) begin
                if (!dmem_ready) m_err = 1;
                m_active = 0;
                m_n = 0;
            end else begin
                m_active = 1;
                m_n++;
            end
        end
        if (!e[10] && m_cnt < (1 << CW) - 1) m_cnt++;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic clear_inputs();
        rs1_ID = 0; rs2_ID = 0; use_rs1_ID = 0; use_rs2_ID = 0; rs1_EX = 0; rs2_EX = 0;
        rd_EX = 0; regwrite_EX = 0; memread_EX = 0; rd_MEM = 0; regwrite_MEM = 0;
        memread_MEM = 0; memwrite_MEM = 0; rd_WB = 0; regwrite_WB = 0;
        branch_taken_EX = 0; dmem_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        memread_MEM = 1; memread_EX = 1; regwrite_EX = 1; rd_EX = 5; rs1_ID = 5; use_rs1_ID = 1;
        regwrite_MEM = 1; rd_MEM = 2; rs1_EX = 2; branch_taken_EX = 1;
        tick();
        tick();
        @(negedge clk);
        n_cmp++; if (ctl !== RUN) begin n_fail++; $display("FAIL reset_ctl got %b want %b", ctl, RUN); end
        n_cmp++; if (fwd !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd got %b want 0000", fwd); end
        n_cmp++; if (stall_cycles !== 0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cycles); end
        n_cmp++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_mem_err got %b want 0", mem_err); end
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_load_use();
        logic [7:0] e;
        do_reset();
        memread_EX = 1; regwrite_EX = 1; rd_EX = 5;
        rs1_ID = 5; rs2_ID = 1; use_rs1_ID = 1; use_rs2_ID = 1;
        @(negedge clk);
        n_cmp++; if (ctl !== LU) begin n_fail++; $display("FAIL load_use_c0 got %b want %b", ctl, LU); end
        tick();
        memread_EX = 0; regwrite_EX = 0; rd_EX = 0;
        memread_MEM = 1; regwrite_MEM = 1; rd_MEM = 5; dmem_ready = 1;
`ifdef PIPE_CTRL_FWD_EN
        e = RUN_REQ;
`else
        e = LU_REQ;
`endif
        @(negedge clk);
        n_cmp++; if (ctl !== e) begin n_fail++; $display("FAIL load_use_c1 got %b want %b", ctl, e); end
        tick();
        memread_MEM = 0; regwrite_MEM = 0; rd_MEM = 0; dmem_ready = 0;
        regwrite_WB = 1; rd_WB = 5;
`ifdef PIPE_CTRL_FWD_EN
        rs1_ID = 0; rs2_ID = 0; use_rs1_ID = 0; use_rs2_ID = 0;
        rs1_EX = 5; rs2_EX = 1;
        @(negedge clk);
        n_cmp++; if (fwd !== 4'b0100) begin n_fail++; $display("FAIL load_use_fwd got %b want 0100", fwd); end
`else
        @(negedge clk);
        n_cmp++; if (fwd !== 4'b0000) begin n_fail++; $display("FAIL load_use_fwd got %b want 0000", fwd); end
`endif
        n_cmp++; if (ctl !== RUN) begin n_fail++; $display("FAIL load_use_c2 got %b want %b", ctl, RUN); end
        tick();
        @(negedge clk);
`ifdef PIPE_CTRL_FWD_EN
        n_cmp++; if (stall_cycles !== 1) begin n_fail++; $display("FAIL load_use_cnt got %0d want 1", stall_cycles); end
`else
        n_cmp++; if (stall_cycles !== 2) begin n_fail++; $display("FAIL load_use_cnt got %0d want 2", stall_cycles); end
`endif
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [3:0] ef;
        do_reset();
        regwrite_EX = 1; rd_EX = 3; rs1_ID = 3; rs2_ID = 4; use_rs1_ID = 1; use_rs2_ID = 1;
        @(negedge clk);
`ifdef PIPE_CTRL_FWD_EN
        n_cmp++; if (ctl !== RUN) begin n_fail++; $display("FAIL b2b_c0 got %b want %b", ctl, RUN); end
        tick();
        regwrite_EX = 0; rd_EX = 0; regwrite_MEM = 1; rd_MEM = 3;
        rs1_ID = 0; rs2_ID = 0; use_rs1_ID = 0; use_rs2_ID = 0; rs1_EX = 3; rs2_EX = 4;
        @(negedge clk);
        n_cmp++; if (fwd !== 4'b1000) begin n_fail++; $display("FAIL b2b_fwd got %b want 1000", fwd); end
        n_cmp++; if (ctl !== RUN) begin n_fail++; $display("FAIL b2b_c1 got %b want %b", ctl, RUN); end
        tick();
        @(negedge clk);
        n_cmp++; if (stall_cycles !== 0) begin n_fail++; $display("FAIL b2b_cnt got %0d want 0", stall_cycles); end
        ef = 4'b1000;
`else
        n_cmp++; if (ctl !== LU) begin n_fail++; $display("FAIL b2b_c0 got %b want %b", ctl, LU); end
        tick();
        regwrite_EX = 0; rd_EX = 0; regwrite_MEM = 1; rd_MEM = 3;
        @(negedge clk);
        n_cmp++; if (ctl !== LU) begin n_fail++; $display("FAIL b2b_c1 got %b want %b", ctl, LU); end
        tick();
        regwrite_MEM = 0; rd_MEM = 0; regwrite_WB = 1; rd_WB = 3;
        @(negedge clk);
        n_cmp++; if (ctl !== RUN) begin n_fail++; $display("FAIL b2b_c2 got %b want %b", ctl, RUN); end
        tick();
        @(negedge clk);
        n_cmp++; if (stall_cycles !== 2) begin n_fail++; $display("FAIL b2b_cnt got %0d want 2", stall_cycles); end
        ef = 4'b0000;
`endif
        clear_inputs();
        regwrite_MEM = 1; rd_MEM = 7; regwrite_WB = 1; rd_WB = 7; rs1_EX = 7; rs2_EX = 9;
        rs1_ID = 7; use_rs1_ID = 0;
        @(negedge clk);
        n_cmp++; if (fwd !== ef) begin n_fail++; $display("FAIL mem_over_wb got %b want %b", fwd, ef); end
        n_cmp++; if (ctl !== RUN) begin n_fail++; $display("FAIL unused_src got %b want %b", ctl, RUN); end
        tick();
        rd_MEM = 0; rd_WB = 0; rs1_EX = 0; rs2_EX = 0;
        regwrite_EX = 1; memread_EX = 1; rd_EX = 0; rs1_ID = 0; rs2_ID = 0; use_rs1_ID = 1; use_rs2_ID = 1;
        @(negedge clk);
        n_cmp++; if (fwd !== 4'b0000) begin n_fail++; $display("FAIL x0_fwd got %b want 0000", fwd); end
        n_cmp++; if (ctl !== RUN) begin n_fail++; $display("FAIL x0_stall got %b want %b", ctl, RUN); end
        tick();
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        memread_MEM = 1; regwrite_MEM = 1; rd_MEM = 8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (ctl !== MSTALL) begin n_fail++; $display("FAIL mem_wait_c%0d got %b want %b", i, ctl, MSTALL); end
            tick();
        end
        dmem_ready = 1;
        @(negedge clk);
        n_cmp++; if (ctl !== RUN_REQ) begin n_fail++; $display("FAIL mem_release got %b want %b", ctl, RUN_REQ); end
        tick();
        memwrite_MEM = 1; memread_MEM = 0; regwrite_MEM = 0;
        @(negedge clk);
        n_cmp++; if (ctl !== RUN_REQ) begin n_fail++; $display("FAIL mem_zero_wait got %b want %b", ctl, RUN_REQ); end
        tick();
        clear_inputs();
        @(negedge clk);
        n_cmp++; if (ctl !== RUN) begin n_fail++; $display("FAIL mem_idle got %b want %b", ctl, RUN); end
        n_cmp++; if (stall_cycles !== 3) begin n_fail++; $display("FAIL mem_wait_cnt got %0d want 3", stall_cycles); end
        tick();
    endtask

    task automatic test_branch_priority();
        do_reset();
        branch_taken_EX = 1;
        memread_EX = 1; regwrite_EX = 1; rd_EX = 5; rs1_ID = 5; use_rs1_ID = 1;
        @(negedge clk);
        n_cmp++; if (ctl !== BR) begin n_fail++; $display("FAIL branch_over_lu got %b want %b", ctl, BR); end
        tick();
        clear_inputs();
        branch_taken_EX = 1; memread_MEM = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (ctl !== MSTALL) begin n_fail++; $display("FAIL branch_held_c%0d got %b want %b", i, ctl, MSTALL); end
            tick();
        end
        dmem_ready = 1;
        @(negedge clk);
        n_cmp++; if (ctl !== BR_REQ) begin n_fail++; $display("FAIL branch_after_stall got %b want %b", ctl, BR_REQ); end
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        memwrite_MEM = 1;
        for (int i = 0; i < TO + 1; i++) begin
            @(negedge clk);
            n_cmp++; if (ctl !== MSTALL) begin n_fail++; $display("FAIL tout_wait_c%0d got %b want %b", i, ctl, MSTALL); end
            tick();
        end
        @(negedge clk);
        n_cmp++; if (ctl !== TOUT) begin n_fail++; $display("FAIL tout_release got %b want %b", ctl, TOUT); end
        tick();
        memwrite_MEM = 0;
        @(negedge clk);
        n_cmp++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL tout_err got %b want 1", mem_err); end
        n_cmp++; if (ctl !== RUN) begin n_fail++; $display("FAIL tout_after got %b want %b", ctl, RUN); end
        n_cmp++; if (stall_cycles !== TO + 1) begin n_fail++; $display("FAIL tout_cnt got %0d want %0d", stall_cycles, TO + 1); end
        repeat (3) tick();
        @(negedge clk);
        n_cmp++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL tout_sticky got %b want 1", mem_err); end
        do_reset();
        memread_MEM = 1;
        repeat (TO + 1) tick();
        dmem_ready = 1;
        @(negedge clk);
        n_cmp++; if (ctl !== RUN_REQ) begin n_fail++; $display("FAIL ready_at_limit got %b want %b", ctl, RUN_REQ); end
        tick();
        clear_inputs();
        @(negedge clk);
        n_cmp++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL ready_at_limit_err got %b want 0", mem_err); end
        memread_MEM = 1;
        tick();
        tick();
        rst = 1;
        @(negedge clk);
        n_cmp++; if (ctl !== RUN) begin n_fail++; $display("FAIL rst_in_wait got %b want %b", ctl, RUN); end
        tick();
        rst = 0;
        memread_MEM = 0;
        @(negedge clk);
        n_cmp++; if ({ctl, mem_err} !== {RUN, 1'b0}) begin n_fail++; $display("FAIL rst_abandon got %b want %b", {ctl, mem_err}, {RUN, 1'b0}); end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        memread_EX = 1; regwrite_EX = 1; rd_EX = 9; rs2_ID = 9; use_rs2_ID = 1;
        repeat (20) tick();
        @(negedge clk);
        n_cmp++; if (stall_cycles !== {CW{1'b1}}) begin n_fail++; $display("FAIL stall_saturate got %0d want %0d", stall_cycles, (1 << CW) - 1); end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [11:0] e;
        do_reset();
        repeat (400) begin
            rst = ($urandom_range(0, 59) == 0);
            rs1_ID = 5'($urandom_range(0, 3)); rs2_ID = 5'($urandom_range(0, 3));
            use_rs1_ID = 1'($urandom); use_rs2_ID = 1'($urandom);
            rs1_EX = 5'($urandom_range(0, 3)); rs2_EX = 5'($urandom_range(0, 3));
            rd_EX = 5'($urandom_range(0, 3)); regwrite_EX = 1'($urandom); memread_EX = 1'($urandom);
            rd_MEM = 5'($urandom_range(0, 3)); regwrite_MEM = 1'($urandom);
            memread_MEM = ($urandom_range(0, 3) == 0); memwrite_MEM = ($urandom_range(0, 5) == 0);
            rd_WB = 5'($urandom_range(0, 3)); regwrite_WB = 1'($urandom);
            branch_taken_EX = ($urandom_range(0, 4) == 0); dmem_ready = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            e = model_out();
            n_cmp++; if ({ctl, fwd} !== e) begin n_fail++; $display("FAIL random_outputs got %b want %b", {ctl, fwd}, e); end
            n_cmp++; if (stall_cycles !== CW'(m_cnt)) begin n_fail++; $display("FAIL random_cnt got %0d want %0d", stall_cycles, m_cnt); end
            n_cmp++; if (mem_err !== m_err) begin n_fail++; $display("FAIL random_err got %b want %b", mem_err, m_err); end
            tick();
        end
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_back_to_back();
        test_mem_wait();
        test_branch_priority();
        test_timeout();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
